// File: rtl/sobel_sdram_drain.sv
// sobel_sdram_drain: empties the 8-bit Sobel magnitude FIFO into fixed-length
// SDRAM write bursts of 16-bit words, generating frame addresses and wrap.
// Build option: define SOBEL_THRESHOLD_EN to emit a binary edge map
// (din >= THRESHOLD -> 16'hFFFF, else 16'h0000) instead of gray RGB565.
module sobel_sdram_drain #(
    parameter int unsigned           BURST_LEN    = 256,
    parameter int unsigned           FRAME_PIXELS = 307200,
    parameter int unsigned           ADDR_WIDTH   = 24,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter logic [7:0]            THRESHOLD    = 8'd16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [9:0]            data_count_r,
    input  logic [7:0]            din,
    output logic                  rd_fifo,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_ack,
    input  logic                  wr_data_req,
    output logic [15:0]           wr_data,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned PIX_W  = $clog2(FRAME_PIXELS + 1);

    localparam logic [BEAT_W-1:0]     LAST_BEAT      = BEAT_W'(BURST_LEN - 1);
    localparam logic [9:0]            BURST_LEN_CNT  = 10'(BURST_LEN);
    localparam logic [PIX_W-1:0]      BURST_LEN_PIX  = PIX_W'(BURST_LEN);
    localparam logic [PIX_W-1:0]      FRAME_END_PIX  = PIX_W'(FRAME_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] BURST_LEN_ADDR = ADDR_WIDTH'(BURST_LEN);
    localparam logic [9:0]            FIFO_FULL      = 10'd1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        TAIL  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [BEAT_W-1:0] beat_cnt;
    logic [PIX_W-1:0]  pix_cnt;
    logic [PIX_W-1:0]  pix_next;
    logic              frame_end;

`ifdef SOBEL_THRESHOLD_EN
    // Binary edge map: any magnitude at or above the level becomes white.
    function automatic logic [15:0] edge_word(input logic [7:0] px);
        return (px >= THRESHOLD) ? 16'hFFFF : 16'h0000;
    endfunction

    assign wr_data = edge_word(din);
`else
    // Saturate the magnitude to 5 bits and replicate it into R, G and B;
    // the green LSB repeats the top bit so full scale stays full scale.
    function automatic logic [15:0] gray565(input logic [7:0] px);
        logic [4:0] g5;
        g5 = (px > 8'd31) ? 5'd31 : px[4:0];
        return {g5, g5, g5[4], g5};
    endfunction

    assign wr_data = gray565(din);
`endif

    assign pix_next  = pix_cnt + BURST_LEN_PIX;
    assign frame_end = (pix_next == FRAME_END_PIX);

    // Next-state and strobes; rd_fifo is a direct pass-through of
    // wr_data_req in BURST so the FIFO word lands exactly when sampled.
    always_comb begin
        state_next = state;
        rd_fifo    = 1'b0;
        wr_req     = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (en && (data_count_r >= BURST_LEN_CNT)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                wr_req = !wr_ack;
                if (wr_ack) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                rd_fifo = wr_data_req;
                if (wr_data_req && (beat_cnt == LAST_BEAT)) begin
                    state_next = TAIL;
                end
            end
            TAIL: begin
                frame_done = frame_end;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Beat counter: cleared when the command is accepted, advanced per data request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if ((state == REQ) && wr_ack) begin
            beat_cnt <= '0;
        end else if ((state == BURST) && wr_data_req) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Frame position: advance address and pixel count once per burst, wrap at frame end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            wr_addr <= BASE_ADDR;
        end else if (state == TAIL) begin
            if (frame_end) begin
                pix_cnt <= '0;
                wr_addr <= BASE_ADDR;
            end else begin
                pix_cnt <= pix_next;
                wr_addr <= wr_addr + BURST_LEN_ADDR;
            end
        end
    end

    // Sticky overflow flag, set whenever the FIFO reports full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (data_count_r == FIFO_FULL) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sobel_sdram_drain.sv
// Directed bench for sobel_sdram_drain with BURST_LEN=4, FRAME_PIXELS=8.
// Two instances share all inputs: one at BASE_ADDR 0, one at BASE_ADDR 0x100.
module tb_sobel_sdram_drain;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst_n, en, wr_ack, wr_data_req;
    logic [9:0]    data_count_r;
    logic [7:0]    din;

    logic          rd_fifo_a, wr_req_a, frame_done_a, overflow_a;
    logic [AW-1:0] wr_addr_a;
    logic [15:0]   wr_data_a;
    logic          rd_fifo_b, wr_req_b, frame_done_b, overflow_b;
    logic [AW-1:0] wr_addr_b;
    logic [15:0]   wr_data_b;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;

    int   rd_total   = 0;
    int   rise_total = 0;
    int   fd_total   = 0;
    logic req_q      = 1'b0;

    always #5 clk = ~clk;

    sobel_sdram_drain #(
        .BURST_LEN(4), .FRAME_PIXELS(8), .ADDR_WIDTH(AW),
        .BASE_ADDR(24'h000000), .THRESHOLD(8'd16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .data_count_r(data_count_r),
        .din(din), .rd_fifo(rd_fifo_a), .wr_req(wr_req_a), .wr_addr(wr_addr_a),
        .wr_ack(wr_ack), .wr_data_req(wr_data_req), .wr_data(wr_data_a),
        .frame_done(frame_done_a), .overflow(overflow_a)
    );

    sobel_sdram_drain #(
        .BURST_LEN(4), .FRAME_PIXELS(8), .ADDR_WIDTH(AW),
        .BASE_ADDR(24'h000100), .THRESHOLD(8'd16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .data_count_r(data_count_r),
        .din(din), .rd_fifo(rd_fifo_b), .wr_req(wr_req_b), .wr_addr(wr_addr_b),
        .wr_ack(wr_ack), .wr_data_req(wr_data_req), .wr_data(wr_data_b),
        .frame_done(frame_done_b), .overflow(overflow_b)
    );

    // Event counters sampled on the active edge.
    always @(posedge clk) begin
        req_q <= wr_req_a;
        if (rd_fifo_a) rd_total <= rd_total + 1;
        if (wr_req_a && !req_q) rise_total <= rise_total + 1;
        if (frame_done_a) fd_total <= fd_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Entered in REQ; hold off the acknowledge for 'delay' cycles, then accept.
    task automatic wait_ack(input int delay);
        for (int i = 0; i < delay; i++) cyc();
        wr_ack = 1'b1;
        settle();
        check("ack_drops_req", 32'(wr_req_a), 32'd0);
        cyc();
        wr_ack = 1'b0;
    endtask

    // Entered on the first BURST cycle; issue 4 data requests, optionally gapped,
    // and return during the TAIL cycle.
    task automatic do_data(input bit gapped);
        int beats;
        int it;
        int rd0;
        beats = 0;
        it    = 0;
        rd0   = rd_total;
        while (beats < 4 && it < 64) begin
            if (it > 0) cyc();
            wr_data_req = gapped ? ($urandom_range(2, 0) != 0) : 1'b1;
            if (wr_data_req) beats++;
            it++;
            settle();
            check("rd_follows_req", 32'(rd_fifo_a), 32'(wr_data_req));
        end
        cyc();
        wr_data_req = 1'b0;
        settle();
        check("tail_no_rd", 32'(rd_fifo_a), 32'd0);
        check("burst_reads", 32'(rd_total - rd0), 32'd4);
    endtask

    logic [7:0]  din_v [4];
    logic [15:0] exp_v [4];
    logic [15:0] exp15, exp16;

    initial begin
        int rd0;
        int rise0;
        int bad;

        din_v = '{8'h05, 8'h1F, 8'h40, 8'h00};
`ifdef SOBEL_THRESHOLD_EN
        exp_v = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
        exp15 = 16'h0000;
        exp16 = 16'hFFFF;
`else
        exp_v = '{16'h2945, 16'hFFFF, 16'hFFFF, 16'h0000};
        exp15 = 16'h7BCF;
        exp16 = 16'h8430;
`endif

        rst_n = 1'b0; en = 1'b0; data_count_r = 10'd0; din = 8'd0;
        wr_ack = 1'b0; wr_data_req = 1'b0;
        repeat (3) cyc();
        settle();
        check("rst_wr_req", 32'(wr_req_a), 32'd0);
        check("rst_rd_fifo", 32'(rd_fifo_a), 32'd0);
        check("rst_addr_a", 32'(wr_addr_a), 32'h0);
        check("rst_addr_b", 32'(wr_addr_b), 32'h100);
        check("rst_frame_done", 32'(frame_done_a), 32'd0);
        check("rst_overflow", 32'(overflow_a), 32'd0);
        check("rst_wr_data", 32'(wr_data_a), 32'h0);

        // Conversion of boundary magnitudes
        din = 8'd15; settle();
        check("conv_15", 32'(wr_data_b), 32'(exp15));
        din = 8'd16; settle();
        check("conv_16", 32'(wr_data_b), 32'(exp16));
        din = 8'd0;

        // Single burst
        cyc();
        rst_n = 1'b1; en = 1'b1; data_count_r = 10'd4;
        settle();
        check("start_cond_no_req_yet", 32'(wr_req_a), 32'd0);
        cyc(); settle();
        check("req_rise", 32'(wr_req_a), 32'd1);
        check("b1_addr_a", 32'(wr_addr_a), 32'h0);
        check("b1_addr_b", 32'(wr_addr_b), 32'h100);
        rd0 = rd_total;
        wait_ack(3);
        data_count_r = 10'd0;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) cyc();
            din = (i > 0) ? din_v[i-1] : 8'h00;
            wr_data_req = (i < 4);
            settle();
            if (i < 4) check("b1_rd_fifo", 32'(rd_fifo_a), 32'd1);
            if (i > 0) check("b1_wr_data", 32'(wr_data_a), 32'(exp_v[i-1]));
        end
        check("b1_tail_no_rd", 32'(rd_fifo_a), 32'd0);
        check("b1_tail_no_frame_done", 32'(frame_done_a), 32'd0);
        cyc(); settle();
        check("b1_reads", 32'(rd_total - rd0), 32'd4);
        check("b1_next_addr_a", 32'(wr_addr_a), 32'h4);
        check("b1_next_addr_b", 32'(wr_addr_b), 32'h104);

        // Request hold, with data requests during REQ ignored
        data_count_r = 10'd4;
        cyc(); settle();
        check("b2_req", 32'(wr_req_a), 32'd1);
        rd0 = rd_total;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            wr_data_req = (i % 2 == 1);
            settle();
            if (!(wr_req_a === 1'b1 && wr_addr_a === 24'h4 && wr_addr_b === 24'h104 && rd_fifo_a === 1'b0))
                bad++;
        end
        wr_data_req = 1'b0;
        check("hold_bad_cycles", 32'(bad), 32'd0);
        check("hold_no_rd", 32'(rd_total - rd0), 32'd0);
        wait_ack(0);
        do_data(1'b0);
        check("b2_frame_done_a", 32'(frame_done_a), 32'd1);
        check("b2_frame_done_b", 32'(frame_done_b), 32'd1);

        // Back-to-back: IDLE then REQ, address wrapped to base
        cyc(); settle();
        check("b2b_idle_no_req", 32'(wr_req_a), 32'd0);
        check("b2b_frame_done_cleared", 32'(frame_done_a), 32'd0);
        cyc(); settle();
        check("b2b_req", 32'(wr_req_a), 32'd1);
        check("wrap_addr_a", 32'(wr_addr_a), 32'h0);
        check("wrap_addr_b", 32'(wr_addr_b), 32'h100);

        // Gapped burst with enable dropped mid-burst
        wait_ack(1);
        en = 1'b0;
        do_data(1'b1);
        check("b3_no_frame_done", 32'(frame_done_a), 32'd0);
        rise0 = rise_total;
        repeat (6) cyc();
        settle();
        check("en_drop_no_req", 32'(wr_req_a), 32'd0);
        check("en_drop_no_rise", 32'(rise_total - rise0), 32'd0);
        check("b3_addr_b", 32'(wr_addr_b), 32'h104);
        check("frame_done_pulses", 32'(fd_total), 32'd1);

        // Stray data requests in IDLE
        rd0 = rd_total;
        for (int i = 0; i < 3; i++) begin
            cyc();
            wr_data_req = 1'b1;
            settle();
            check("stray_no_rd", 32'(rd_fifo_a), 32'd0);
            cyc();
            wr_data_req = 1'b0;
        end
        settle();
        check("stray_count", 32'(rd_total - rd0), 32'd0);

        // Overflow, sticky
        check("ovf_before", 32'(overflow_a), 32'd0);
        cyc();
        data_count_r = 10'd1023;
        cyc();
        data_count_r = 10'd4;
        settle();
        check("ovf_set", 32'(overflow_a), 32'd1);
        repeat (3) cyc();
        settle();
        check("ovf_sticky", 32'(overflow_b), 32'd1);
        check("ovf_no_req_en_low", 32'(wr_req_a), 32'd0);

        // Reset mid-burst
        en = 1'b1;
        cyc(); settle();
        check("b4_req", 32'(wr_req_a), 32'd1);
        wait_ack(0);
        wr_data_req = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc(); settle();
        check("rst_mid_rd_fifo", 32'(rd_fifo_a), 32'd0);
        check("rst_mid_wr_req", 32'(wr_req_a), 32'd0);
        check("rst_mid_addr_a", 32'(wr_addr_a), 32'h0);
        check("rst_mid_addr_b", 32'(wr_addr_b), 32'h100);
        check("rst_mid_overflow", 32'(overflow_a), 32'd0);
        check("rst_mid_frame_done", 32'(frame_done_a), 32'd0);
        wr_data_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc(); settle();
        check("post_rst_req", 32'(wr_req_a), 32'd1);
        wait_ack(2);
        do_data(1'b0);
        check("post_rst_no_frame_done", 32'(frame_done_a), 32'd0);
        data_count_r = 10'd0;
        cyc(); settle();
        check("post_rst_addr_a", 32'(wr_addr_a), 32'h4);
        check("post_rst_addr_b", 32'(wr_addr_b), 32'h104);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
